// File: rtl/program_loader_if.sv
// Host word stream into the loader and the program memory write port out of it.
interface program_loader_if #(
   parameter int ADDR_W = 10
);
   logic              host_valid;
   logic              host_ready;
   logic [15:0]       host_data;
   logic              host_last;
   logic              pm_we;
   logic [ADDR_W-1:0] pm_wr_addr;
   logic [31:0]       pm_wr_data;

   modport master (
      output host_valid, host_data, host_last,
      input  host_ready, pm_we, pm_wr_addr, pm_wr_data
   );

   modport slave (
      input  host_valid, host_data, host_last,
      output host_ready, pm_we, pm_wr_addr, pm_wr_data
   );
endinterface

// File: rtl/program_loader.sv
// Pairs 16-bit host words into 32-bit instructions (high half first), writes them to
// program memory at consecutive addresses and gates run_program on a clean, complete load.
module program_loader #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_start,
   program_loader_if.slave      bus,
   output logic [31:0]          pc_max,
   output logic                 load_done,
   output logic                 err_odd,
   output logic                 err_overflow,
   input  logic                 run_req,
   output logic                 run_program
);
   typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [15:0]       hi;
   logic              hs;

   assign hs          = bus.host_valid & bus.host_ready;
   assign run_program = run_req & load_done & ~err_odd & ~err_overflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         hi             <= '0;
         bus.host_ready <= 1'b0;
         bus.pm_we      <= 1'b0;
         bus.pm_wr_addr <= '0;
         bus.pm_wr_data <= '0;
         pc_max         <= '0;
         load_done      <= 1'b0;
         err_odd        <= 1'b0;
         err_overflow   <= 1'b0;
      end else begin
         bus.pm_we <= 1'b0;
         // A restart wins over any handshake in the same cycle; that word is dropped.
         if (load_start && !run_program) begin
            state          <= LOAD_HI;
            cnt            <= '0;
            pc_max         <= '0;
            load_done      <= 1'b0;
            err_odd        <= 1'b0;
            err_overflow   <= 1'b0;
            bus.host_ready <= 1'b1;
         end else begin
            case (state)
               IDLE: bus.host_ready <= 1'b0;
               LOAD_HI: begin
                  if (!bus.host_ready) begin
                     // End of the commit bubble that follows every low-word write.
                     bus.host_ready <= 1'b1;
                  end else if (bus.host_valid) begin
                     hi <= bus.host_data;
                     if (bus.host_last) begin
                        err_odd        <= 1'b1;
                        load_done      <= 1'b1;
                        bus.host_ready <= 1'b0;
                        state          <= DONE;
                     end else begin
                        state <= LOAD_LO;
                     end
                  end
               end
               LOAD_LO: begin
                  if (hs) begin
                     bus.pm_we      <= 1'b1;
                     bus.pm_wr_addr <= cnt;
                     bus.pm_wr_data <= {hi, bus.host_data};
                     pc_max         <= 32'(cnt) + 32'd1;
                     cnt            <= cnt + 1'b1;
                     bus.host_ready <= 1'b0;
                     if (bus.host_last) begin
                        load_done <= 1'b1;
                        state     <= DONE;
                     end else if (cnt == LAST_ADDR) begin
                        err_overflow <= 1'b1;
                        load_done    <= 1'b1;
                        state        <= DONE;
                     end else begin
                        state <= LOAD_HI;
                     end
                  end
               end
               DONE: begin
                  bus.host_ready <= 1'b0;
                  load_done      <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader with a word-count reference model.
module tb_program_loader;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic        run_req;
   logic [31:0] pc_max;
   logic        load_done, err_odd, err_overflow, run_program;

   program_loader_if #(.ADDR_W(AW)) bus();

   program_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_start   (load_start),
      .bus          (bus),
      .pc_max       (pc_max),
      .load_done    (load_done),
      .err_odd      (err_odd),
      .err_overflow (err_overflow),
      .run_req      (run_req),
      .run_program  (run_program)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [15:0] words[$];
   int          exp_pc;
   bit          exp_odd, exp_ovf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the next expected write.
   always @(negedge clk) begin
      if (bus.pm_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%0h:%0h required=none", bus.pm_wr_addr, bus.pm_wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.pm_wr_addr), 32'(mon_e.addr));
            chk("wr_data", bus.pm_wr_data, mon_e.data);
         end
      end
   end

   // Reference model: outcome of a program of n words whose last word carries host_last.
   task automatic expect_program(input int n);
      int np = n / 2;
      int nw = (np < DEPTH) ? np : DEPTH;
      for (int i = 0; i < nw; i++)
         exp_q.push_back('{addr: AW'(i), data: {words[2*i], words[2*i+1]}});
      exp_pc  = nw;
      exp_ovf = (n > 2 * DEPTH);
      exp_odd = (n % 2 == 1) && !exp_ovf;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
   endtask

   task automatic drive(input bit with_last, input bit gaps);
      int idx    = 0;
      int budget = 300;
      while (idx < words.size()) begin
         bus.host_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.host_data  = words[idx];
         bus.host_last  = with_last && (idx == words.size() - 1);
         @(negedge clk);
         if (bus.host_valid && bus.host_ready) idx++;
         @(posedge clk); #1;
         if (idx < words.size() && load_done) break;
         budget--;
         if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout actual=%0d required=%0d words", idx, words.size());
            break;
         end
      end
      bus.host_valid = 1'b0;
      bus.host_last  = 1'b0;
   endtask

   task automatic finish_check();
      repeat (2) @(posedge clk);
      #1;
      chk("pc_max", pc_max, 32'(exp_pc));
      chk("load_done", 32'(load_done), 32'd1);
      chk("err_odd", 32'(err_odd), 32'(exp_odd));
      chk("err_overflow", 32'(err_overflow), 32'(exp_ovf));
      chk("host_ready_done", 32'(bus.host_ready), 32'd0);
      chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic program_test(input bit gaps);
      start_load();
      expect_program(words.size());
      drive(1'b1, gaps);
      finish_check();
   endtask

   task automatic reset_outputs_check(input string tag);
      chk({tag, "_pc_max"}, pc_max, 32'd0);
      chk({tag, "_load_done"}, 32'(load_done), 32'd0);
      chk({tag, "_err"}, 32'({err_odd, err_overflow}), 32'd0);
      chk({tag, "_host_ready"}, 32'(bus.host_ready), 32'd0);
      chk({tag, "_pm_we"}, 32'(bus.pm_we), 32'd0);
      chk({tag, "_pm_bus"}, 32'(bus.pm_wr_addr) | bus.pm_wr_data, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      load_start     = 1'b0;
      run_req        = 1'b0;
      bus.host_valid = 1'b0;
      bus.host_data  = '0;
      bus.host_last  = 1'b0;
      #12;
      reset_outputs_check("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_host_ready", 32'(bus.host_ready), 32'd0);
      run_req = 1'b1;
      #1 chk("run_before_load", 32'(run_program), 32'd0);
      run_req = 1'b0;

      words = '{16'h4001, 16'h0002, 16'h4003, 16'h0004, 16'h8005, 16'h0000};
      program_test(1'b0);
      program_test(1'b1);

      words = '{16'h1111, 16'h2222, 16'h3333};
      program_test(1'b1);
      run_req = 1'b1;
      #1 chk("run_after_odd", 32'(run_program), 32'd0);
      run_req = 1'b0;

      words.delete();
      for (int i = 0; i < 10; i++) words.push_back(16'($urandom));
      program_test(1'b1);

      // Restart coincident with a low-word handshake.
      words = '{16'hA001, 16'hA002, 16'hA003};
      start_load();
      exp_q.push_back('{addr: AW'(0), data: {16'hA001, 16'hA002}});
      drive(1'b0, 1'b0);
      bus.host_valid = 1'b1;
      bus.host_data  = 16'hDEAD;
      load_start     = 1'b1;
      @(negedge clk);
      chk("restart_ready", 32'(bus.host_ready), 32'd1);
      @(posedge clk); #1;
      load_start     = 1'b0;
      bus.host_valid = 1'b0;
      words = '{16'hB001, 16'hB002};
      expect_program(2);
      drive(1'b1, 1'b0);
      finish_check();

      for (int t = 0; t < 8; t++) begin
         words.delete();
         for (int i = 0; i < int'($urandom_range(1, 11)); i++) words.push_back(16'($urandom));
         program_test(1'($urandom_range(0, 1)));
      end

      // Run gating, load_start while running, then reset mid-load.
      words = '{16'h7001, 16'h7002, 16'h7003, 16'h7004};
      start_load();
      run_req = 1'b1;
      #1 chk("run_during_load", 32'(run_program), 32'd0);
      expect_program(4);
      drive(1'b1, 1'b1);
      finish_check();
      chk("run_after_good", 32'(run_program), 32'd1);
      start_load();
      chk("ignored_pc_max", pc_max, 32'd2);
      chk("ignored_load_done", 32'(load_done), 32'd1);
      chk("ignored_host_ready", 32'(bus.host_ready), 32'd0);
      run_req = 1'b0;
      words = '{16'hC001, 16'hC002};
      start_load();
      drive(1'b0, 1'b0);
      chk("pending_we", 32'(bus.pm_we), 32'd1);
      rst = 1'b1;
      #1;
      reset_outputs_check("async_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_pc_max", pc_max, 32'd0);
      chk("post_rst_outstanding", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Upstream feeder for the program driver. It accepts a stream of 16-bit host words over a valid/ready handshake and pairs them into 32-bit instructions, high half first. It writes each instruction into program memory at consecutive addresses and publishes the instruction count as pc_max. It gates run_program so the driver only runs a complete, error-free program.

Parameters:
DEPTH, 1024, program memory capacity in 32-bit instructions (power of two, >=2)
ADDR_W, 10, program memory address width, equal to log2(DEPTH)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
load_start  in  1  single-cycle pulse: begin (or restart) a program load
host_valid  in  1  host word valid
host_ready  out  1  loader can accept a host word
host_data  in  16  host word
host_last  in  1  qualifies the final word of the program (with host_valid)
pm_we  out  1  program memory write strobe (single cycle)
pm_wr_addr  out  ADDR_W  program memory write address
pm_wr_data  out  32  instruction {hi_word, lo_word}
pc_max  out  32  instructions written, zero-extended
load_done  out  1  level: load finished, held until next load_start
err_odd  out  1  level: host_last arrived on a high-half word
err_overflow  out  1  level: more than DEPTH instructions offered
run_req  in  1  level request from controller to execute
run_program  out  1  to driver: run_req & load_done & ~err_odd & ~err_overflow (combinational)

Behaviour:
- Reset values:
  - State IDLE.
  - host_ready, pm_we, load_done, err_odd, err_overflow = 0.
  - pm_wr_addr = 0, pm_wr_data = 0, pc_max = 0.
  - Internal address counter and hi register = 0.
- A handshake occurs on a cycle where host_valid & host_ready are both high. Words without a handshake are ignored.
- State IDLE:
  - host_ready = 0.
  - load_start -> LOAD_HI. Clear addr counter, pc_max, load_done, both errors.
- State LOAD_HI (host_ready = 1):
  - Handshake: capture host_data into hi.
  - If host_last -> err_odd = 1, go to DONE. Nothing is written.
  - Otherwise -> LOAD_LO.
- State LOAD_LO (host_ready = 1). On a handshake:
  - Next cycle: pm_we = 1, pm_wr_addr = counter, pm_wr_data = {hi, host_data}, pc_max = counter + 1.
  - Counter increments in the same update.
  - If host_last -> DONE.
  - Else, if counter was DEPTH-1 -> err_overflow = 1, go to DONE. pc_max = DEPTH; the counter does not wrap into a write.
  - Else -> LOAD_HI.
- State DONE:
  - host_ready = 0, load_done = 1.
  - Outputs stay frozen until load_start.
- Latency:
  - Write appears one cycle after the low-word handshake.
  - load_done rises in the same cycle as the final pm_we, or one cycle after the error-causing handshake.
- host_ready is registered. It is 0 in the cycle after every low-word handshake (a commit bubble), so the maximum rate is 2 words per 3 cycles.
- load_start in any state, including mid-load:
  - Abort and re-enter LOAD_HI with counter, pc_max, flags cleared.
  - A handshake in that same cycle is discarded.
  - No pm_we is issued for the discarded word.
- load_start is ignored while run_program = 1.
- Asynchronous reset mid-load:
  - Immediate return to reset values.
  - Any pending pm_we is dropped.
  - Partial memory contents are left as-is but are invalid, since pc_max = 0.
- pm_we is never asserted outside the cycle following a LOAD_LO handshake.

Test Plan:
- Normal load:
  - Stimulus: load_start, then 6 back-to-back words 0x4001,0x0002,0x4003,0x0004,0x8005,0x0000 (last on the 6th).
  - Required: writes addr0=0x40010002, addr1=0x40030004, addr2=0x80050000; pc_max=3; load_done=1; host_ready=0 afterward.
- Backpressure and gaps:
  - Stimulus: same program, host_valid toggling randomly.
  - Required: identical memory contents, pc_max=3. No write occurs without a preceding low-word handshake.
- Odd length:
  - Stimulus: 3 words with host_last on the 3rd.
  - Required: one write (addr0), pc_max=1, err_odd=1, load_done=1. run_program stays 0 with run_req=1.
- Overflow, DEPTH=4:
  - Stimulus: 10 words, last on the 10th.
  - Required: writes addr0..3 only, pc_max=4, err_overflow=1, loader in DONE after the 8th word, host_ready=0.
- Restart mid-load:
  - Stimulus: after 3 words, pulse load_start coincident with a handshake, then send 2 words with last.
  - Required: single write at addr0 with the new pair, pc_max=1. The discarded word never appears.
- Run gating and reset:
  - Stimulus: run_req=1 before load, during load, and after a good load; then pulse load_start while running; then assert rst mid-load.
  - Required:
    - run_program=0, 0, 1 respectively.
    - The load_start while running is ignored.
    - Under rst, all outputs go to 0 asynchronously.
